// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the MIPS core.
// Holds the NOP/END instruction words and the IF stage state encoding,
// which instruction_decode also uses to interpret o_state.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] END_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IF_LOAD = 2'b00,
    IF_RUN  = 2'b01,
    IF_DONE = 2'b10
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the IF stage and its neighbours (debug unit, hazard unit, ID).
//   master: drives program load, start/step, stall and jump; reads IF/ID.
//   slave : the IF stage itself.
// Signals:
//   i_load_en/i_load_addr/i_load_data  program write port
//   i_start, i_step_en                 run control from the debug unit
//   i_stall                            hazard hold
//   i_jump, i_jump_address             ID-resolved redirect
//   o_instruction, o_pc                IF/ID register contents
//   o_state, o_halted                  fetch FSM status
interface instruction_fetch_if #(
  parameter int unsigned IMEM_ADDR_W = 8
);

  logic                   i_load_en;
  logic [IMEM_ADDR_W-1:0] i_load_addr;
  logic [31:0]            i_load_data;
  logic                   i_start;
  logic                   i_step_en;
  logic                   i_stall;
  logic                   i_jump;
  logic [31:0]            i_jump_address;
  logic [31:0]            o_instruction;
  logic [31:0]            o_pc;
  logic [1:0]             o_state;
  logic                   o_halted;

  modport master (
    output i_load_en, i_load_addr, i_load_data, i_start, i_step_en,
           i_stall, i_jump, i_jump_address,
    input  o_instruction, o_pc, o_state, o_halted
  );

  modport slave (
    input  i_load_en, i_load_addr, i_load_data, i_start, i_step_en,
           i_stall, i_jump, i_jump_address,
    output o_instruction, o_pc, o_state, o_halted
  );

endinterface

// File: rtl/instruction_memory.sv
// Instruction memory: 2**IMEM_ADDR_W 32-bit words.
// One synchronous write port, one combinational read port. Contents are
// never cleared so a loaded program survives reset.
// Ports:
//   i_clk               clock
//   i_we/i_waddr/i_wdata write port (rising edge)
//   i_raddr/o_rdata     asynchronous read port
module instruction_memory #(
  parameter int unsigned IMEM_ADDR_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [IMEM_ADDR_W-1:0] i_waddr,
  input  logic [31:0]            i_wdata,
  input  logic [IMEM_ADDR_W-1:0] i_raddr,
  output logic [31:0]            o_rdata
);

  logic [31:0] mem_q [0:(1 << IMEM_ADDR_W) - 1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction memory and the
// IF/ID register. The debug unit loads the program in LOAD, i_start begins
// RUN, and fetching stops (DONE) when the END word 0xFFFFFFFF is fetched.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   bus (slave)     load port, run control, stall/jump, IF/ID outputs
// Build option:
//   IMEM_BYTE_LOAD_EN  program is loaded one byte per strobe (MSB first)
//                      into sequential words; i_load_addr is unused.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 8,
  parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  instruction_fetch_if.slave bus
);

  if_state_e              state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            opc_q, opc_d;
  logic [31:0]            fetch_word;
  logic                   advance;
  logic                   mem_we;
  logic [IMEM_ADDR_W-1:0] mem_waddr;
  logic [31:0]            mem_wdata;

  assign advance = bus.i_step_en & ~bus.i_stall;

  instruction_memory #(
    .IMEM_ADDR_W(IMEM_ADDR_W)
  ) u_imem (
    .i_clk  (i_clk),
    .i_we   (mem_we),
    .i_waddr(mem_waddr),
    .i_wdata(mem_wdata),
    .i_raddr(pc_q[IMEM_ADDR_W+1:2]),
    .o_rdata(fetch_word)
  );

  // ---------------- FSM state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IF_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_LOAD: begin
        if (bus.i_start) state_d = IF_RUN;
      end
      IF_RUN: begin
        // A jump flushes the fetched word, so END only counts on a sequential fetch.
        if (advance && !bus.i_jump && fetch_word == END_INSTR) state_d = IF_DONE;
      end
      IF_DONE: begin
        if (bus.i_start)        state_d = IF_RUN;
        else if (bus.i_load_en) state_d = IF_LOAD;
      end
      default: state_d = IF_LOAD;
    endcase
  end

  // ---------------- FSM outputs: PC and IF/ID ----------------
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    unique case (state_q)
      IF_LOAD: begin
        instr_d = NOP_INSTR;
        if (bus.i_start) pc_d = PC_RESET;
      end
      IF_RUN: begin
        if (advance) begin
          opc_d = pc_q + 32'd4;
          if (bus.i_jump) begin
            pc_d    = bus.i_jump_address;
            instr_d = NOP_INSTR;
          end else begin
            instr_d = fetch_word;
            // PC parks on the END word so the halt address stays visible.
            if (fetch_word != END_INSTR) pc_d = pc_q + 32'd4;
          end
        end
      end
      IF_DONE: begin
        if (bus.i_start)        pc_d    = PC_RESET;
        else if (bus.i_load_en) instr_d = NOP_INSTR;
      end
      default: begin
        pc_d    = PC_RESET;
        instr_d = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q    <= PC_RESET;
      instr_q <= NOP_INSTR;
      opc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  // ---------------- Program load path ----------------
`ifdef IMEM_BYTE_LOAD_EN
  logic [1:0]             bcnt_q, bcnt_d;
  logic [IMEM_ADDR_W-1:0] wptr_q, wptr_d;
  logic [23:0]            asm_q, asm_d;

  always_comb begin
    bcnt_d = bcnt_q;
    wptr_d = wptr_q;
    asm_d  = asm_q;
    mem_we = 1'b0;
    if (state_q == IF_LOAD) begin
      if (bus.i_load_en) begin
        asm_d  = {asm_q[15:0], bus.i_load_data[7:0]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + IMEM_ADDR_W'(1);
        end
      end
      // Leaving LOAD drops any partially assembled word.
      if (bus.i_start) bcnt_d = '0;
    end else if (state_d == IF_LOAD) begin
      bcnt_d = '0;
      wptr_d = '0;
    end
  end

  assign mem_waddr = wptr_q;
  assign mem_wdata = {asm_q, bus.i_load_data[7:0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bcnt_q <= '0;
      wptr_q <= '0;
      asm_q  <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      wptr_q <= wptr_d;
      asm_q  <= asm_d;
    end
  end
`else
  assign mem_we    = (state_q == IF_LOAD) & bus.i_load_en;
  assign mem_waddr = bus.i_load_addr;
  assign mem_wdata = bus.i_load_data;
`endif

  assign bus.o_instruction = instr_q;
  assign bus.o_pc          = opc_q;
  assign bus.o_state       = state_q;
  assign bus.o_halted      = (state_q == IF_DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// a randomized run, all checked against a behavioural model of the IF stage.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;

  instruction_fetch_if #(.IMEM_ADDR_W(8)) bus ();

  instruction_fetch #(
    .IMEM_ADDR_W(8),
    .PC_RESET   (32'h0000_0000)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Behavioural model: memory image, PC, IF/ID and run state (0 LOAD, 1 RUN, 2 DONE).
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_opc;
  int          m_state;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (rst) begin
      m_state = 0; m_pc = 32'h0; m_instr = 32'h0; m_opc = 32'h0;
      return;
    end
    case (m_state)
      0: begin
        m_instr = 32'h0;
        if (bus.i_start) begin m_state = 1; m_pc = 32'h0; end
      end
      1: begin
        if (bus.i_step_en && !bus.i_stall) begin
          w = m_mem[(m_pc >> 2) % 256];
          m_opc = m_pc + 32'd4;
          if (bus.i_jump) begin
            m_instr = 32'h0;
            m_pc    = bus.i_jump_address;
          end else begin
            m_instr = w;
            if (w == 32'hFFFF_FFFF) m_state = 2;
            else m_pc = m_pc + 32'd4;
          end
        end
      end
      default: begin
        if (bus.i_start) begin m_state = 1; m_pc = 32'h0; end
        else if (bus.i_load_en) begin m_state = 0; m_instr = 32'h0; end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("instr",  bus.o_instruction, m_instr);
    chk("pc",     bus.o_pc, m_opc);
    chk("state",  32'(bus.o_state), m_state);
    chk("halted", 32'(bus.o_halted), (m_state == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic load_word(input int unsigned addr, input logic [31:0] data);
    logic [31:0] d;
    m_mem[addr] = data;
`ifdef IMEM_BYTE_LOAD_EN
    d = data;
    for (int b = 0; b < 4; b++) begin
      bus.i_load_en   = 1'b1;
      bus.i_load_addr = 8'($urandom);
      bus.i_load_data = {$urandom_range(0, 255) << 8} | {24'h0, d[31:24]};
      cycle();
      d = d << 8;
    end
`else
    d = data;
    bus.i_load_en   = 1'b1;
    bus.i_load_addr = addr[7:0];
    bus.i_load_data = d;
    cycle();
`endif
    bus.i_load_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == 32'hFFFF_FFFF);
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    bus.i_load_en = 1'b0; bus.i_load_addr = '0; bus.i_load_data = '0;
    bus.i_start = 1'b0; bus.i_step_en = 1'b0; bus.i_stall = 1'b0;
    bus.i_jump = 1'b0; bus.i_jump_address = '0;

    cycle(); cycle();
    chk("reset_instr", bus.o_instruction, 32'h0);
    chk("reset_state", 32'(bus.o_state), 32'd0);
    rst = 1'b0;

    // Program 1: spec example, remainder random non-END filler.
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      w = 32'h2008_0005;
      else if (i == 1) w = 32'h2009_0007;
      else if (i == 2) w = 32'hFFFF_FFFF;
      else             w = rand_word();
      load_word(i, w);
    end

    bus.i_start = 1'b1; cycle(); bus.i_start = 1'b0;
    chk("start_nop", bus.o_instruction, 32'h0);
    bus.i_step_en = 1'b1;
    cycle(); chk("p1_w0", bus.o_instruction, 32'h2008_0005); chk("p1_pc0", bus.o_pc, 32'h4);
    cycle(); chk("p1_w1", bus.o_instruction, 32'h2009_0007); chk("p1_pc1", bus.o_pc, 32'h8);
    // Stall with a simultaneous jump: both edges hold, jump ignored.
    bus.i_stall = 1'b1; bus.i_jump = 1'b1; bus.i_jump_address = 32'h80;
    cycle(); cycle();
    chk("stall_hold_i", bus.o_instruction, 32'h2009_0007); chk("stall_hold_pc", bus.o_pc, 32'h8);
    bus.i_stall = 1'b0; bus.i_jump = 1'b0;
    cycle();
    chk("p1_end", bus.o_instruction, 32'hFFFF_FFFF); chk("p1_pcC", bus.o_pc, 32'hC);
    chk("p1_halt", 32'(bus.o_halted), 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus.i_step_en = 1'($urandom); bus.i_stall = 1'($urandom);
      bus.i_jump = 1'($urandom); bus.i_jump_address = $urandom;
      cycle();
      chk("done_frozen", bus.o_instruction, 32'hFFFF_FFFF);
    end
    bus.i_stall = 1'b0; bus.i_jump = 1'b0; bus.i_step_en = 1'b1;

    // Restart directly from DONE.
    bus.i_start = 1'b1; cycle(); bus.i_start = 1'b0;
    chk("rerun_state", 32'(bus.o_state), 32'd1);
    cycle(); chk("rerun_w0", bus.o_instruction, 32'h2008_0005);
    for (int i = 0; i < 10 && m_state != 2; i++) cycle();
    chk("rerun_done", 32'(bus.o_state), 32'd2);

    // DONE -> LOAD on a load strobe, then program 2 with END at word 60.
    bus.i_load_en = 1'b1; cycle(); bus.i_load_en = 1'b0;
    chk("reload_state", 32'(bus.o_state), 32'd0);
    for (int i = 0; i < 256; i++) load_word(i, (i == 60) ? 32'hFFFF_FFFF : rand_word());

    bus.i_start = 1'b1; cycle(); bus.i_start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("p2_pc10", bus.o_pc, 32'h10);
    bus.i_jump = 1'b1; bus.i_jump_address = 32'h40; bus.i_stall = 1'b1;
    cycle();
    chk("jstall_hold", bus.o_pc, 32'h10);
    bus.i_stall = 1'b0;
    cycle(); chk("jump_nop", bus.o_instruction, 32'h0); chk("jump_pc", bus.o_pc, 32'h14);
    bus.i_jump = 1'b0;
    cycle(); chk("jump_tgt", bus.o_instruction, m_mem[16]); chk("jump_tgt_pc", bus.o_pc, 32'h44);
    // Unaligned target near the top of the address space: index and PC wrap.
    bus.i_jump = 1'b1; bus.i_jump_address = 32'hFFFF_FFFD;
    cycle(); bus.i_jump = 1'b0;
    cycle(); chk("wrap_word", bus.o_instruction, m_mem[255]); chk("wrap_pc", bus.o_pc, 32'h1);

    // Reset mid-RUN at PC 0x20, program survives and reruns.
    rst = 1'b1; cycle(); rst = 1'b0;
    bus.i_start = 1'b1; cycle(); bus.i_start = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    chk("pre_rst_pc", bus.o_pc, 32'h20);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mid_rst_state", 32'(bus.o_state), 32'd0);
    chk("mid_rst_instr", bus.o_instruction, 32'h0);
    bus.i_start = 1'b1; cycle(); bus.i_start = 1'b0;
    cycle(); chk("rerun2_w0", bus.o_instruction, m_mem[0]); chk("rerun2_pc", bus.o_pc, 32'h4);

    // Randomized run.
    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 99) == 0);
      bus.i_step_en     = ($urandom_range(0, 3) != 0);
      bus.i_stall       = ($urandom_range(0, 3) == 0);
      bus.i_jump        = ($urandom_range(0, 4) == 0);
      bus.i_jump_address = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 80) * 4) : $urandom;
      bus.i_start       = (m_state != 1) && ($urandom_range(0, 2) == 0);
      cycle();
    end
    rst = 1'b0; bus.i_start = 1'b0; bus.i_jump = 1'b0; bus.i_stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
